fifo_uart_tx: RTL and testbench

//  Downstream drain stage for fifo_top: pops bytes (read_signal/data_out) when the FIFO is
//  non-empty and transmits each one as an 8N1 serial frame on tx.

---
 rtl/fifo_uart_tx_pkg.sv | 22 ++
 rtl/fifo_uart_tx_bit_timer.sv | 42 ++++
 rtl/fifo_uart_tx.sv | 108 ++++++++++
 tb/tb_fifo_uart_tx.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_tx_pkg.sv
// State encodings and line levels shared by the FIFO-draining 8N1 UART transmitter.
package fifo_uart_tx_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_LOAD  = 3'd2,
        S_START = 3'd3,
        S_DATA  = 3'd4,
        S_STOP  = 3'd5
    } state_e;

    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;

    // The bit timer is held at zero until the start bit begins.
    function automatic logic is_setup_state(input state_e s);
        return (s == S_IDLE) || (s == S_READ) || (s == S_LOAD);
    endfunction

endpackage

// File: rtl/fifo_uart_tx_bit_timer.sv
// Bit-period counter: wraps 0..CLKS_PER_BIT-1, flags the last and second-to-last clock.
module fifo_uart_tx_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick,
    output logic pre_tick
);
    import fifo_uart_tx_pkg::*;

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] PRE  = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;

    // Next count: restart on clear or at the end of each bit period.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (clear || tick) begin
            cnt_nxt_s = '0;
        end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    assign tick     = (cnt_r == LAST);
    assign pre_tick = (cnt_r == PRE);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains fifo_top one byte at a time and sends each byte as an 8N1 frame on tx.
module fifo_uart_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              read_signal,
    output logic              tx,
    output logic              busy,
    output logic              byte_done
);
    import fifo_uart_tx_pkg::*;

    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    state_e            state_r;
    logic [DATA_W-1:0] shift_r;
    logic [IDX_W-1:0]  bit_idx_r;
    logic              tick_s;
    logic              pre_tick_s;
    logic              clear_s;

    assign clear_s = is_setup_state(state_r);

    fifo_uart_tx_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear_s),
        .tick     (tick_s),
        .pre_tick (pre_tick_s)
    );

    // Frame FSM; every output is set one clock ahead so it lines up with its state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            shift_r     <= '0;
            bit_idx_r   <= '0;
            read_signal <= 1'b0;
            tx          <= IDLE_LVL;
            busy        <= 1'b0;
            byte_done   <= 1'b0;
        end else begin
            read_signal <= 1'b0;
            byte_done   <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        state_r     <= S_READ;
                        read_signal <= 1'b1;
                        busy        <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                S_READ: begin
                    state_r <= S_LOAD;
                end
                S_LOAD: begin
                    shift_r   <= fifo_data;
                    bit_idx_r <= '0;
                    tx        <= START_LVL;
                    state_r   <= S_START;
                end
                S_START: begin
                    if (tick_s) begin
                        tx      <= shift_r[0];
                        state_r <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (tick_s) begin
                        if (bit_idx_r == LAST_IDX) begin
                            tx      <= STOP_LVL;
                            state_r <= S_STOP;
                        end else begin
                            shift_r   <= shift_r >> 1;
                            tx        <= shift_r[1];
                            bit_idx_r <= bit_idx_r + IDX_W'(1);
                        end
                    end
                end
                S_STOP: begin
                    // pre_tick marks the clock before the last stop-bit clock.
                    byte_done <= pre_tick_s;
                    if (tick_s) begin
                        tx      <= IDLE_LVL;
                        busy    <= 1'b0;
                        state_r <= S_IDLE;
                    end
                end
                default: begin
                    state_r     <= S_IDLE;
                    tx          <= IDLE_LVL;
                    busy        <= 1'b0;
                    read_signal <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed and table-driven bench for fifo_uart_tx with a FIFO model and a UART receiver model.
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // [0] = start bit ... [9] = stop bit
        string      name;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       fifo_empty;
    logic [7:0] fifo_data = 8'h00;
    logic       read_signal;
    logic       tx;
    logic       busy;
    logic       byte_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rd_count = 0;
    int bd_count = 0;
    int rx_ferr = 0;
    logic [7:0] fifo_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    vec_t vecs[5];

    fifo_uart_tx #(.DATA_W(8), .CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fifo_empty  (fifo_empty),
        .fifo_data   (fifo_data),
        .read_signal (read_signal),
        .tx          (tx),
        .busy        (busy),
        .byte_done   (byte_done)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // FIFO model, pulse counters, consecutive-pop check and UART receiver, all on negedge.
    initial begin
        logic       prev_rd;
        logic       rx_act;
        int         rx_cnt;
        int         rx_bit;
        logic [7:0] rx_sh;
        prev_rd = 1'b0;
        rx_act  = 1'b0;
        rx_cnt  = 0;
        rx_sh   = 8'h00;
        forever begin
            @(negedge clk);
            if (read_signal === 1'b1) begin
                rd_count = rd_count + 1;
                checks = checks + 1;
                if (prev_rd === 1'b1) begin
                    errors = errors + 1;
                    $display("FAIL read_consecutive: read_signal high on two clocks at cycle %0d", cyc);
                end
                checks = checks + 1;
                if (fifo_q.size() > 0) begin
                    fifo_data = fifo_q.pop_front();
                end else begin
                    errors = errors + 1;
                    $display("FAIL pop_when_empty: read_signal=1 with empty FIFO at cycle %0d", cyc);
                end
            end
            prev_rd = read_signal;
            if (byte_done === 1'b1) bd_count = bd_count + 1;
            if (rst_n !== 1'b1) begin
                rx_act = 1'b0;
            end else if (!rx_act) begin
                if (tx === 1'b0) begin
                    rx_act = 1'b1;
                    rx_cnt = 0;
                end
            end else begin
                rx_cnt = rx_cnt + 1;
                if (rx_cnt % CPB == 2) begin
                    rx_bit = rx_cnt / CPB;
                    if (rx_bit == 0) begin
                        if (tx !== 1'b0) begin
                            rx_ferr = rx_ferr + 1;
                            rx_act = 1'b0;
                        end
                    end else if (rx_bit <= 8) begin
                        rx_sh[rx_bit-1] = tx;
                    end else begin
                        if (tx !== 1'b1) rx_ferr = rx_ferr + 1;
                        else rx_q.push_back(rx_sh);
                        rx_act = 1'b0;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks = checks + 1;
        if (act !== want) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    // Entered on a negedge before the READ cycle; leaves at the READ negedge.
    task automatic wait_read(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (read_signal !== 1'b1 && n < 200) begin
            @(negedge clk);
            n = n + 1;
        end
        checks = checks + 1;
        if (read_signal !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL %s: got no read_signal within 200 clocks, want a pulse", name);
        end
    endtask

    // Entered at the READ negedge; checks LOAD plus all 40 frame clocks.
    task automatic check_frame(input logic [9:0] bits, input string name, input int empty_at);
        int   bad;
        logic exp_tx;
        logic exp_bd;
        bad = 0;
        for (int k = 0; k <= 10 * CPB; k++) begin
            @(negedge clk);
            if (k == empty_at) fifo_empty = 1'b1;
            exp_tx = (k == 0) ? 1'b1 : bits[(k - 1) / CPB];
            exp_bd = (k == 10 * CPB);
            if (tx !== exp_tx || byte_done !== exp_bd || busy !== 1'b1 || read_signal !== 1'b0) begin
                if (bad == 0)
                    $display("FAIL %s: clock %0d got tx=%b byte_done=%b busy=%b read=%b want tx=%b byte_done=%b busy=1 read=0",
                             name, k, tx, byte_done, busy, read_signal, exp_tx, exp_bd);
                bad = bad + 1;
            end
        end
        checks = checks + 1;
        if (bad != 0) errors = errors + 1;
    endtask

    initial begin
        int t1;
        int t2;
        int rd0;
        int bd0;
        int bad;
        int n;
        logic [7:0] b;

        vecs[0] = '{data: 8'hA5, frame: 10'h34A, name: "frame_a5"};
        vecs[1] = '{data: 8'h00, frame: 10'h200, name: "frame_00"};
        vecs[2] = '{data: 8'h80, frame: 10'h300, name: "frame_80"};
        vecs[3] = '{data: 8'h3C, frame: 10'h278, name: "frame_3c"};
        vecs[4] = '{data: 8'hFF, frame: 10'h3FE, name: "frame_ff"};

        // Reset values, then 50 idle clocks with an empty FIFO.
        rst_n = 1'b0;
        fifo_empty = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", {28'd0, tx, read_signal, busy, byte_done}, 32'h8);
        rst_n = 1'b1;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx !== 1'b1 || read_signal !== 1'b0 || busy !== 1'b0 || byte_done !== 1'b0) bad = bad + 1;
        end
        check("idle_50_clocks_changes", bad, 0);

        // One byte per table entry: full tx waveform, one pop, one byte_done.
        for (int i = 0; i < 5; i++) begin
            rd0 = rd_count;
            bd0 = bd_count;
            fifo_q.push_back(vecs[i].data);
            fifo_empty = 1'b0;
            wait_read({vecs[i].name, "_read"});
            check_frame(vecs[i].frame, vecs[i].name, 0);
            repeat (5) @(negedge clk);
            check({vecs[i].name, "_pops"}, rd_count - rd0, 1);
            check({vecs[i].name, "_byte_done_pulses"}, bd_count - bd0, 1);
            check({vecs[i].name, "_idle_after"}, {30'd0, busy, tx}, 32'h1);
        end

        // Back-to-back 0x01, 0x02 with the FIFO never empty.
        fifo_q.push_back(8'h01);
        fifo_q.push_back(8'h02);
        fifo_empty = 1'b0;
        wait_read("b2b_read0");
        t1 = cyc;
        check_frame(10'h202, "b2b_frame_01", -1);
        @(negedge clk);
        check("b2b_gap_idle", {30'd0, read_signal, tx}, 32'h1);
        @(negedge clk);
        check("b2b_gap_read", {30'd0, read_signal, tx}, 32'h3);
        t2 = cyc;
        check("b2b_read_spacing", t2 - t1, 10 * CPB + 3);
        check_frame(10'h204, "b2b_frame_02", 0);
        repeat (3) @(negedge clk);

        // FIFO goes empty during the first data bit: frame completes, no second pop.
        fifo_q.push_back(8'h3C);
        fifo_q.push_back(8'h77);
        fifo_empty = 1'b0;
        wait_read("midframe_empty_read");
        rd0 = rd_count;
        check_frame(10'h278, "midframe_empty_frame", CPB + 1);
        @(negedge clk);
        check("midframe_empty_busy_after_stop", {31'd0, busy}, 32'h0);
        repeat (20) @(negedge clk);
        check("midframe_empty_no_second_pop", rd_count - rd0, 0);
        fifo_q.delete();

        // Reset during data bit 3 of 0xFF: the byte is dropped and 0x5A follows cleanly.
        rx_q.delete();
        fifo_q.push_back(8'hFF);
        fifo_q.push_back(8'h5A);
        fifo_empty = 1'b0;
        wait_read("reset_mid_read");
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("reset_mid_async_outputs", {28'd0, tx, read_signal, busy, byte_done}, 32'h8);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_read("reset_mid_fresh_read");
        check_frame(10'h2B4, "reset_mid_fresh_frame", 0);
        repeat (3) @(negedge clk);
        check("reset_mid_rx_count", rx_q.size(), 1);
        if (rx_q.size() > 0) check("reset_mid_rx_byte", {24'd0, rx_q[0]}, 32'h5A);

        // 256 random bytes decoded by the receiver model, in FIFO order.
        rx_q.delete();
        for (int i = 0; i < 256; i++) begin
            b = 8'($urandom_range(0, 255));
            fifo_q.push_back(b);
            exp_q.push_back(b);
        end
        n = 0;
        while (rx_q.size() < 256 && n < 12000) begin
            @(negedge clk);
            fifo_empty = (fifo_q.size() == 0);
            n = n + 1;
        end
        fifo_empty = 1'b1;
        check("random_rx_count", rx_q.size(), 256);
        for (int i = 0; i < 256; i++) begin
            if (i < rx_q.size()) check("random_rx_byte", {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
        end
        check("rx_framing_errors", rx_ferr, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
